// File: rtl/pin_input_monitor.sv
// Pin input monitor: synchronises and debounces the raw pad inputs, then
// raises edge events. A small register window exposes the filtered values,
// the per-pin rise/fall enables and the W1C event bits.
module pin_input_monitor #(
    parameter int PinNum    = 87,
    parameter int DebounceW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [PinNum-1:0]    pins_i,
    input  logic [DebounceW-1:0] debounce_limit_i,
    output logic [PinNum-1:0]    pins_o,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [3:0]           addr_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 irq_o
);

    // Each register bank is three 32-bit words; bits at or above PinNum are
    // held at zero by this mask.
    localparam int RegW = 96;
    localparam logic [RegW-1:0] ValidMask = {RegW{1'b1}} >> (RegW - PinNum);

    logic [PinNum-1:0]    sync1, sync2, sample, filt;
    logic [PinNum-1:0]    agree, rose, fell;
    logic [DebounceW-1:0] cnt;
    logic                 tick;
    logic [RegW-1:0]      rise_en, fall_en, evt, clr, rd_src;
    logic [31:0]          rd_word;
    logic [1:0]           grp, widx;
    logic                 wr;

    // The >= compare lets a lowered limit take effect at once without
    // the counter having to wrap through zero first.
    assign tick  = (cnt >= debounce_limit_i);
    assign grp   = addr_i[3:2];
    assign widx  = addr_i[1:0];
    assign wr    = req_i & we_i & (widx != 2'd3);

    // filt only moves when two consecutive ticks agree, so the change
    // qualifiers below are the edge events for this cycle.
    assign agree = ~(sync2 ^ sample);
    assign rose  = {PinNum{tick}} & agree & sync2 & ~filt;
    assign fell  = {PinNum{tick}} & agree & ~sync2 & filt;

    assign pins_o = filt;
    assign irq_o  = |evt;

    // Free-running sample-tick divider, one tick every limit+1 cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt <= '0;
        else       cnt <= tick ? '0 : cnt + 1'b1;
    end

    // Two-flop synchroniser followed by the two-sample agreement filter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1  <= '0;
            sync2  <= '0;
            sample <= '0;
            filt   <= '0;
        end else begin
            sync1 <= pins_i;
            sync2 <= sync1;
            if (tick) begin
                sample <= sync2;
                filt   <= (filt & ~agree) | (sync2 & agree);
            end
        end
    end

    // W1C clear mask for the addressed EVENT word.
    always_comb begin
        clr = '0;
        if (wr && grp == 2'd3) clr[32*widx +: 32] = wdata_i;
    end

    // Enable registers; only implemented bits can be written.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_en <= '0;
            fall_en <= '0;
        end else if (wr) begin
            if (grp == 2'd1) rise_en[32*widx +: 32] <= wdata_i & ValidMask[32*widx +: 32];
            if (grp == 2'd2) fall_en[32*widx +: 32] <= wdata_i & ValidMask[32*widx +: 32];
        end
    end

    // Event latch: a new event on the same edge as its clear wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) evt <= '0;
        else       evt <= ((evt & ~clr) | (RegW'(rose) & rise_en)
                           | (RegW'(fell) & fall_en)) & ValidMask;
    end

    // Read mux; word index 3 of every bank is unmapped.
    always_comb begin
        case (grp)
            2'd0:    rd_src = RegW'(filt);
            2'd1:    rd_src = rise_en;
            2'd2:    rd_src = fall_en;
            default: rd_src = evt;
        endcase
        rd_word = (widx == 2'd3) ? 32'd0 : rd_src[32*widx +: 32];
    end

    // Registered response, one cycle after each access; data only on reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= (req_i && !we_i) ? rd_word : 32'd0;
        end
    end

endmodule

// File: tb/tb_pin_input_monitor.sv
// Bench for pin_input_monitor: directed scenarios plus a random phase, all
// checked every cycle against a per-pin behavioural model.
module tb_pin_input_monitor;

    localparam int N  = 87;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  pins;
    logic [DW-1:0] lim;
    logic [N-1:0]  pins_out;
    logic          req, we;
    logic [3:0]    addr;
    logic [31:0]   wdata, rdata;
    logic          rvalid, irq;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pin_input_monitor #(.PinNum(N), .DebounceW(DW)) dut (
        .clk_i(clk), .rst_i(rst), .pins_i(pins), .debounce_limit_i(lim),
        .pins_o(pins_out), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .irq_o(irq)
    );

    // Reference model: per-pin history of what the synchroniser has seen,
    // the value recorded at the previous tick, and the register banks.
    bit [95:0] m_flt, m_smp, m_d1, m_d2, m_ren, m_fen, m_evt, vmask;
    int        m_since;
    bit        m_rvalid;
    bit [31:0] m_rdata;

    function automatic bit [31:0] m_word(bit [3:0] a);
        bit [95:0] src;
        case (a[3:2])
            2'd0:    src = m_flt;
            2'd1:    src = m_ren;
            2'd2:    src = m_fen;
            default: src = m_evt;
        endcase
        if (a[1:0] == 2'd3) return 32'd0;
        return src[32*a[1:0] +: 32];
    endfunction

    task automatic model_edge();
        bit        tk;
        bit [95:0] newev, clr;
        int        k;
        if (rst) begin
            m_flt = '0; m_smp = '0; m_d1 = '0; m_d2 = '0;
            m_ren = '0; m_fen = '0; m_evt = '0;
            m_since = 0; m_rvalid = 0; m_rdata = '0;
            return;
        end
        m_rvalid = req;
        m_rdata  = (req && !we) ? m_word(addr) : 32'd0;
        // A tick fires once limit cycles have elapsed since the last one.
        tk = (m_since >= int'(lim));
        m_since = tk ? 0 : m_since + 1;
        newev = '0;
        if (tk) begin
            for (int i = 0; i < N; i++) begin
                if (m_d2[i] == m_smp[i] && m_d2[i] != m_flt[i]) begin
                    if (m_d2[i] && m_ren[i])  newev[i] = 1'b1;
                    if (!m_d2[i] && m_fen[i]) newev[i] = 1'b1;
                    m_flt[i] = m_d2[i];
                end
                m_smp[i] = m_d2[i];
            end
        end
        m_d2 = m_d1;
        m_d1 = 96'(pins);
        clr = '0;
        k = int'(addr[1:0]);
        if (req && we && k != 3) begin
            case (addr[3:2])
                2'd1: m_ren[32*k +: 32] = wdata & vmask[32*k +: 32];
                2'd2: m_fen[32*k +: 32] = wdata & vmask[32*k +: 32];
                2'd3: clr[32*k +: 32]   = wdata;
                default: ;
            endcase
        end
        m_evt = (m_evt & ~clr) | newev;
    endtask

    task automatic check(string tag, logic [95:0] obs, logic [95:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs stay stable across the edge, model advances, and
    // the DUT is sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("pins_o",   96'(pins_out), m_flt);
        check("irq_o",    96'(irq),      96'(|m_evt));
        check("rvalid_o", 96'(rvalid),   96'(m_rvalid));
        check("rdata_o",  96'(rdata),    96'(m_rdata));
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(bit [3:0] a, bit [31:0] d);
        req = 1; we = 1; addr = a; wdata = d;
        step();
        req = 0; we = 0;
    endtask

    task automatic rd(bit [3:0] a);
        req = 1; we = 0; addr = a;
        step();
        req = 0;
    endtask

    initial begin
        vmask = '0;
        for (int i = 0; i < N; i++) vmask[i] = 1'b1;
        rst = 1; pins = '0; lim = '0; req = 0; we = 0; addr = '0; wdata = '0;
        steps(3);
        check("rst_pins", 96'(pins_out), 96'd0);
        check("rst_irq",  96'(irq),      96'd0);
        rst = 0;

        // Rise on pin 0 with limit 0: visible after the fourth edge.
        wr(4'd4, 32'h1);
        pins[0] = 1'b1;
        steps(3);
        check("e035_pin0_early", 96'(pins_out[0]), 96'd0);
        step();
        check("e035_pin0", 96'(pins_out[0]), 96'd1);
        check("e035_irq",  96'(irq),         96'd1);
        rd(4'd12);
        check("e035_rd12", 96'(rdata), 96'h1);

        // Clear and new rise on the same edge: the set wins.
        pins[0] = 1'b0;
        steps(4);
        pins[0] = 1'b1;
        steps(3);
        wr(4'd12, 32'h1);
        check("e038_irq", 96'(irq), 96'd1);
        rd(4'd12);
        check("e038_rd12", 96'(rdata), 96'h1);
        wr(4'd12, 32'h1);
        check("e038_clr_irq", 96'(irq), 96'd0);

        // Short pulse on pin 6 with limit 3 is filtered out; a long one is not.
        lim = 16'd3;
        wr(4'd4, 32'h41);
        pins[6] = 1'b1;
        steps(2);
        pins[6] = 1'b0;
        steps(16);
        check("e036_glitch", 96'(pins_out[6]), 96'd0);
        check("e036_noirq",  96'(irq),         96'd0);
        pins[6] = 1'b1;
        steps(12);
        check("e036_stable", 96'(pins_out[6]), 96'd1);

        // Fall event on pin 86, then W1C clear.
        lim = 16'd0;
        wr(4'd12, 32'hFFFF_FFFF);
        wr(4'd10, 32'h0040_0000);
        pins[86] = 1'b1;
        steps(4);
        pins[86] = 1'b0;
        steps(4);
        rd(4'd14);
        check("e037_rd14", 96'(rdata), 96'h0040_0000);
        wr(4'd14, 32'h0040_0000);
        check("e037_irq", 96'(irq), 96'd0);
        rd(4'd14);
        check("e037_rd14_clr", 96'(rdata), 96'd0);

        // Upper-bank masking and unmapped reads.
        wr(4'd6, 32'hFFFF_FFFF);
        rd(4'd6);
        check("e039_rd6", 96'(rdata), 96'h007F_FFFF);
        rd(4'd3);
        check("e039_rd3", 96'(rdata), 96'd0);
        pins[86:64] = '1;
        steps(4);
        rd(4'd2);
        check("e039_rd2", 96'(rdata), 96'h007F_FFFF);

        // Reset mid-count with events pending and an access in flight.
        lim = 16'd5;
        pins = '0;
        pins[0] = 1'b1;
        steps(2);
        rst = 1; req = 1; we = 0; addr = 4'd12;
        step();
        req = 0;
        check("e040_pins", 96'(pins_out), 96'd0);
        check("e040_irq",  96'(irq),      96'd0);
        check("e040_rv",   96'(rvalid),   96'd0);
        rst = 0;
        step();
        check("e040_rv_after", 96'(rvalid), 96'd0);
        steps(10);
        check("e040_pin0_early", 96'(pins_out[0]), 96'd0);
        step();
        check("e040_pin0", 96'(pins_out[0]), 96'd1);
        check("e040_noirq", 96'(irq), 96'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) lim = DW'($urandom_range(0, 4));
            if ($urandom_range(0, 2) == 0) pins[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 4) == 0) pins[$urandom_range(0, 3)] ^= 1'b1;
            rst = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 3) == 0) begin
                req = 1; we = $urandom_range(0, 1) == 1;
                addr = 4'($urandom_range(0, 15)); wdata = $urandom;
            end
            step();
            req = 0; we = 0; rst = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
